seq_detector_prog: RTL and testbench

- Run-time programmable serial pattern detector. Generalises the fixed 4-bit Moore detector to any pattern of 1..MAX_LEN bits.
- Adds overlap/non-overlap mode, input-valid gating, a saturating match counter and configuration error reporting.
- Sits on a serial bit stream (framing/sync-word hunt) and drives a one-cycle detect pulse to downstream control.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_det_hist.sv | 46 ++++
 rtl/seq_detector_prog.sv | 104 ++++++++++
 tb/tb_seq_detector_prog.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);
  localparam int MASK_W      = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating fill counter.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               clr,
  input  logic               restart,
  input  logic               din,
  output logic [MAX_LEN-1:0] hist_next,
  output logic [LEN_W-1:0]   fill_next
);

  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  always_comb begin
    hist_next = hist_q;
    fill_next = fill_q;
    if (shift_en) begin
      hist_next = {hist_q[MAX_LEN-2:0], din};
      if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_next = fill_q + LEN_W'(1);
      end
    end
  end

  // restart empties the fill on a non-overlap match; bits stay for debug
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_next;
      fill_q <= restart ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector with match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = 16,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             state_q;
  state_t             state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               cfg_ok;
  logic               shift_en;
  logic               match;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic               detect_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  assign cfg_ok = (pat_len != '0) && (int'(pat_len) <= MAX_LEN);
  assign shift_en = (state_q == RUN) && din_valid && !cfg_load;
  assign mask = MAX_LEN'(len_mask(int'(len_q)));
  assign match = shift_en && (fill_next >= len_q)
              && (((hist_next ^ pat_q) & mask) == '0);

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clr       (cfg_load),
    .restart   (match && !ovl_q),
    .din       (din),
    .hist_next (hist_next),
    .fill_next (fill_next)
  );

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = cfg_ok ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        pat_q <= pattern;
        len_q <= pat_len;
        ovl_q <= overlap_en;
      end
    end
  end

  // clear wins first, so a same-edge match lands on a count of one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detect_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      detect_q <= match;
      err_q    <= cfg_load && !cfg_ok;
      if (count_clr) begin
        cnt_q <= match ? CNT_W'(1) : '0;
      end else if (match && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign detect      = detect_q;
  assign cfg_err     = err_q;
  assign match_count = cnt_q;
  assign armed       = (state_q == RUN);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench: directed vector table plus random stream against a queue model.
module tb_seq_detector_prog;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       cfg_load;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic       overlap_en;
  logic       count_clr;
  logic       detect;
  logic [15:0] match_count;
  logic       cfg_err;
  logic       armed;
  logic       detect2;
  logic [1:0] match_count2;
  logic       cfg_err2;
  logic       armed2;

  int n_chk;
  int n_err;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap_en  (overlap_en),
    .count_clr   (count_clr),
    .detect      (detect),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap_en  (overlap_en),
    .count_clr   (count_clr),
    .detect      (detect2),
    .match_count (match_count2),
    .cfg_err     (cfg_err2),
    .armed       (armed2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queue of bits seen since the last restart point
  bit         m_run;
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  bit         m_det;
  bit         m_err;
  int         m_cnt;
  int         m_cnt2;

  task automatic model_reset();
    m_run = 0; m_pat = '0; m_len = 0; m_ovl = 0;
    m_q.delete(); m_det = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_edge(input bit b, input bit v, input bit cfg,
                            input bit [7:0] p, input int l,
                            input bit o, input bit clr);
    bit hit;
    hit = 0;
    m_err = 0;
    if (cfg) begin
      m_pat = p; m_len = l; m_ovl = o;
      m_run = (l >= 1 && l <= 8);
      m_err = !m_run;
      m_q.delete();
    end else if (m_run && v) begin
      m_q.push_back(b);
      if (m_q.size() > 8) void'(m_q.pop_front());
      if (m_q.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (m_q[m_q.size()-1-i] != m_pat[i]) hit = 0;
      end
      if (hit && !m_ovl) m_q.delete();
    end
    m_det = hit;
    if (clr) begin
      m_cnt = hit ? 1 : 0;
      m_cnt2 = hit ? 1 : 0;
    end else if (hit) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".detect"}, int'(detect), int'(m_det));
    chk({tag, ".count"}, int'(match_count), m_cnt);
    chk({tag, ".cfg_err"}, int'(cfg_err), int'(m_err));
    chk({tag, ".armed"}, int'(armed), int'(m_run));
    chk({tag, ".count2"}, int'(match_count2), m_cnt2);
    chk({tag, ".detect2"}, int'(detect2), int'(m_det));
  endtask

  task automatic step(input bit b, input bit v, input bit cfg,
                      input bit [7:0] p, input int l,
                      input bit o, input bit clr);
    @(negedge clk);
    din = b; din_valid = v; cfg_load = cfg;
    pattern = p; pat_len = 4'(l); overlap_en = o; count_clr = clr;
    @(posedge clk);
    model_edge(b, v, cfg, p, l, o, clr);
    #1;
  endtask

  typedef struct {
    bit       b;
    bit       v;
    bit       cfg;
    bit [7:0] p;
    int       l;
    bit       o;
    bit       clr;
    int       det;
    int       cnt;
    int       cnt2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit b, input bit v, input bit cfg,
                     input bit [7:0] p, input int l, input bit o,
                     input bit clr, input int det, input int cnt,
                     input int cnt2);
    vec_t t;
    t.b = b; t.v = v; t.cfg = cfg; t.p = p; t.l = l; t.o = o;
    t.clr = clr; t.det = det; t.cnt = cnt; t.cnt2 = cnt2;
    tbl.push_back(t);
  endtask

  task automatic bit_(input bit b, input int det, input int cnt,
                      input int cnt2);
    add(b, 1, 0, 8'h00, 0, 0, 0, det, cnt, cnt2);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 0; din = 0; din_valid = 0; cfg_load = 0;
    pattern = '0; pat_len = '0; overlap_en = 0; count_clr = 0;
    model_reset();
    #12;
    chk_model("reset");
    chk("reset.detect_c", int'(detect), 0);
    rst_n = 1;

    // overlap 1011: detects after bits 4 and 7
    add(0, 0, 1, 8'b0000_1011, 4, 1, 0, 0, 0, 0);
    bit_(1, 0, 0, 0); bit_(0, 0, 0, 0); bit_(1, 0, 0, 0);
    bit_(1, 1, 1, 1); bit_(0, 0, 1, 1); bit_(1, 0, 1, 1);
    bit_(1, 1, 2, 2);
    // non-overlap: only one more
    add(0, 0, 1, 8'b0000_1011, 4, 0, 0, 0, 2, 2);
    bit_(1, 0, 2, 2); bit_(0, 0, 2, 2); bit_(1, 0, 2, 2);
    bit_(1, 1, 3, 3); bit_(0, 0, 3, 3); bit_(1, 0, 3, 3);
    bit_(1, 0, 3, 3);
    // gaps do not break a partial match
    add(0, 0, 1, 8'b0000_1011, 4, 1, 0, 0, 3, 3);
    bit_(1, 0, 3, 3); bit_(0, 0, 3, 3);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 3, 3);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0, 3, 3);
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 3, 3);
    bit_(1, 0, 3, 3); bit_(1, 1, 4, 3);
    // illegal lengths
    add(0, 0, 1, 8'hff, 0, 1, 0, 0, 4, 3);
    add(0, 0, 1, 8'hff, 9, 1, 0, 0, 4, 3);
    bit_(1, 0, 4, 3); bit_(1, 0, 4, 3); bit_(1, 0, 4, 3);
    // pat_len 1, saturation on the narrow counter
    add(0, 0, 1, 8'h01, 1, 1, 1, 0, 0, 0);
    bit_(1, 1, 1, 1); bit_(1, 1, 2, 2); bit_(1, 1, 3, 3);
    bit_(1, 1, 4, 3); bit_(1, 1, 5, 3);
    add(1, 1, 0, 8'h00, 0, 0, 1, 1, 1, 1);
    // bit in the cfg_load cycle is discarded
    add(1, 1, 1, 8'h01, 1, 1, 0, 0, 1, 1);
    bit_(0, 0, 1, 1); bit_(1, 1, 2, 2);
    // full-length pattern
    add(0, 0, 1, 8'b1010_0110, 8, 1, 0, 0, 2, 2);
    bit_(1, 0, 2, 2); bit_(0, 0, 2, 2); bit_(1, 0, 2, 2);
    bit_(0, 0, 2, 2); bit_(0, 0, 2, 2); bit_(1, 0, 2, 2);
    bit_(1, 0, 2, 2); bit_(0, 1, 3, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].v, tbl[i].cfg, tbl[i].p, tbl[i].l,
           tbl[i].o, tbl[i].clr);
      chk_model($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.det_c", i), int'(detect), tbl[i].det);
      chk($sformatf("vec%0d.cnt_c", i), int'(match_count), tbl[i].cnt);
      chk($sformatf("vec%0d.cnt2_c", i), int'(match_count2), tbl[i].cnt2);
      if (tbl[i].cfg)
        chk($sformatf("vec%0d.err_c", i), int'(cfg_err),
            int'(tbl[i].l == 0 || tbl[i].l > 8));
    end

    // mid-stream async reset
    step(0, 0, 1, 8'b0000_1011, 4, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    rst_n = 0;
    #2;
    model_reset();
    chk_model("async_rst");
    chk("async_rst.armed_c", int'(armed), 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 1, 0, 0, 0, 0, 0);
    chk_model("post_rst1");
    step(1, 1, 0, 0, 0, 0, 0);
    chk_model("post_rst2");
    chk("post_rst.det_c", int'(detect), 0);
    chk("post_rst.armed_c", int'(armed), 0);

    // randomized stream
    for (int i = 0; i < 3000; i++) begin
      bit       cfg;
      bit [7:0] p;
      int       l;
      cfg = ($urandom_range(0, 39) == 0) || (i == 0);
      p = 8'($urandom);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9)
                                      : $urandom_range(1, 3);
      step(1'($urandom), $urandom_range(0, 3) != 0, cfg, p, l,
           1'($urandom), $urandom_range(0, 49) == 0);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
